// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-enable divider controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int MIN_DIV = 2;
    localparam int NUM_REQ = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grants only while adv is high and then
// hands preference to the requester that just lost.
module rr_arb2
    import clk_div_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               adv,
    output logic [NUM_REQ-1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = '0;
        if (adv) begin
            if (!ptr) begin
                if (req[0])      gnt = 2'b01;
                else if (req[1]) gnt = 2'b10;
            end else begin
                if (req[1])      gnt = 2'b10;
                else if (req[0]) gnt = 2'b01;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst)        ptr <= 1'b0;
        else if (gnt[0]) ptr <= 1'b1;
        else if (gnt[1]) ptr <= 1'b0;
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable divider with boundary-aligned ratio updates.
// Optional period counter output enabled by CLK_DIV_CTRL_STATS_EN.
//
// state | meaning
// IDLE  | en low; count and outputs held at 0
// RUN   | counting, no ratio update pending
// PEND  | counting, granted ratio waits for the period boundary
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int DEF_DIV = 5
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       req,
    input  logic [CNT_W-1:0] req_div0,
    input  logic [CNT_W-1:0] req_div1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div,
    output logic             div_tick,
`ifdef CLK_DIV_CTRL_STATS_EN
    output logic [15:0]      period_cnt,
`endif
    output logic             div_out
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [CNT_W-1:0] div_nx;
    logic [CNT_W-1:0] pend_div, pend_nx, pend_eff;
    logic [CNT_W-1:0] req_sel, req_clamped;
    logic             busy_nx;
    logic             last;
    logic             run_nx;
    logic             tick_nx, out_nx;
    logic             arb_adv;
    logic [1:0]       arb_gnt;

    assign arb_adv = (state != PEND) && !busy;

    rr_arb2 u_arb (
        .clk_in (clk_in),
        .rst    (rst),
        .req    (req),
        .adv    (arb_adv),
        .gnt    (arb_gnt)
    );

    // The offered ratio is sampled during the grant cycle itself.
    assign req_sel     = gnt[1] ? req_div1 : req_div0;
    assign req_clamped = (req_sel < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : req_sel;
    assign pend_nx     = (|gnt) ? req_clamped : pend_div;
    assign pend_eff    = pend_nx;
    assign last        = (count == cur_div - CNT_W'(1));

    always_comb begin
        state_nx = state;
        count_nx = count;
        div_nx   = cur_div;
        busy_nx  = busy;
        case (state)
            IDLE: begin
                if (busy) begin
                    div_nx  = pend_eff;
                    busy_nx = 1'b0;
                end
                if (en) begin
                    count_nx = '0;
                    state_nx = RUN;
                end
            end
            RUN, PEND: begin
                count_nx = last ? '0 : count + CNT_W'(1);
                // A grant whose sampling cycle is the boundary waits a full period.
                if (state == PEND && !(|gnt) && last) begin
                    div_nx   = pend_eff;
                    busy_nx  = 1'b0;
                    state_nx = RUN;
                end
                if (!en) begin
                    state_nx = IDLE;
                    count_nx = '0;
                    if (busy) begin
                        div_nx  = pend_eff;
                        busy_nx = 1'b0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                count_nx = '0;
            end
        endcase
        if (|arb_gnt) begin
            busy_nx  = 1'b1;
            state_nx = (state_nx == IDLE) ? IDLE : PEND;
        end
    end

    assign run_nx  = (state_nx != IDLE);
    assign tick_nx = run_nx && (count_nx == div_nx - CNT_W'(1));
    assign out_nx  = run_nx && (count_nx < (div_nx >> 1));

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            cur_div  <= CNT_W'(DEF_DIV);
            pend_div <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            div_tick <= 1'b0;
            div_out  <= 1'b0;
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            cur_div  <= div_nx;
            pend_div <= pend_nx;
            gnt      <= arb_gnt;
            busy     <= busy_nx;
            div_tick <= tick_nx;
            div_out  <= out_nx;
        end
    end

`ifdef CLK_DIV_CTRL_STATS_EN
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst)
            period_cnt <= '0;
        else if (!en)
            period_cnt <= '0;
        else if (div_tick && period_cnt != 16'hFFFF)
            period_cnt <= period_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized bench for clk_div_ctrl against a period/phase reference model.
module tb_clk_div_ctrl;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] req;
    logic [7:0] req_div0, req_div1;
    logic [1:0] gnt;
    logic       busy;
    logic [7:0] cur_div;
    logic       div_tick;
    logic       div_out;
`ifdef CLK_DIV_CTRL_STATS_EN
    logic [15:0] period_cnt;
`endif

    clk_div_ctrl #(.CNT_W(8), .DEF_DIV(5)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .req_div0 (req_div0),
        .req_div1 (req_div1),
        .gnt      (gnt),
        .busy     (busy),
        .cur_div  (cur_div),
        .div_tick (div_tick),
`ifdef CLK_DIV_CTRL_STATS_EN
        .period_cnt (period_cnt),
`endif
        .div_out  (div_out)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0d exp=%0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: running flag, position within the current period,
    // period length in effect and the ratio promised for a later period.
    bit         m_run;
    int         m_phase;
    int         m_n;
    int         m_new;
    bit         m_busy;
    bit         m_ptr;
    logic [1:0] m_gnt;
    int         m_pcnt;

    function automatic int clampv(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_phase = 0; m_n = 5; m_new = 0;
        m_busy = 0; m_ptr = 0; m_gnt = 2'b00; m_pcnt = 0;
    endtask

    task automatic model_step();
        bit         end_of_period;
        bit         grant_cycle;
        int         sel_new;
        logic [1:0] g;
        if (!rst) begin
            model_reset();
            return;
        end
        end_of_period = m_run && (m_phase == m_n - 1);
        grant_cycle   = (m_gnt != 2'b00);
        sel_new       = grant_cycle ? clampv(m_gnt[0] ? int'(req_div0) : int'(req_div1)) : m_new;
        g = 2'b00;
        if (!m_busy && req != 2'b00) begin
            if (req[m_ptr]) g = m_ptr ? 2'b10 : 2'b01;
            else            g = m_ptr ? 2'b01 : 2'b10;
            m_ptr = g[0];
        end
        if (!en) m_pcnt = 0;
        else if (end_of_period && m_pcnt < 65535) m_pcnt++;
        if (!en) begin
            if (m_busy) begin m_n = sel_new; m_busy = 0; end
            m_run = 0; m_phase = 0;
        end else if (!m_run) begin
            if (m_busy) begin m_n = sel_new; m_busy = 0; end
            m_run = 1; m_phase = 0;
        end else begin
            if (m_busy && !grant_cycle && end_of_period) begin
                m_n = sel_new; m_busy = 0;
            end
            m_phase = end_of_period ? 0 : m_phase + 1;
        end
        m_new = sel_new;
        if (g != 2'b00) m_busy = 1;
        m_gnt = g;
    endtask

    task automatic compare_all();
        check("gnt",      32'(gnt),      32'(m_gnt));
        check("busy",     32'(busy),     32'(m_busy));
        check("cur_div",  32'(cur_div),  32'(m_n));
        check("div_tick", 32'(div_tick), 32'(m_run && (m_phase == m_n - 1)));
        check("div_out",  32'(div_out),  32'(m_run && (m_phase < m_n / 2)));
`ifdef CLK_DIV_CTRL_STATS_EN
        check("period_cnt", 32'(period_cnt), 32'(m_pcnt));
`endif
    endtask

    // Requesters drop their bit once granted; new requests arrive at rate p_req %.
    task automatic drive_req(input int p_req);
        for (int i = 0; i < 2; i++) begin
            if (req[i] && m_gnt[i]) begin
                req[i] = 1'b0;
            end else if (!req[i] && !m_gnt[i] && $urandom_range(99) < p_req) begin
                req[i] = 1'b1;
                if (i == 0) req_div0 = 8'($urandom_range(0, 9));
                else        req_div1 = 8'($urandom_range(0, 9));
            end
        end
    endtask

    task automatic cycle(input int p_req);
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        compare_all();
        drive_req(p_req);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; req = 2'b00; req_div0 = '0; req_div1 = '0;
        model_reset();
        @(negedge clk_in);
        compare_all();
        check("rst_cur_div", 32'(cur_div), 32'd5);
        rst = 1'b1;

        // Free-running at the default ratio.
        en = 1'b1;
        repeat (16) cycle(0);

        // Single request, ratio 3.
        req[0] = 1'b1; req_div0 = 8'd3;
        repeat (20) cycle(0);

        // Simultaneous requests 4 and 6.
        req = 2'b11; req_div0 = 8'd4; req_div1 = 8'd6;
        repeat (30) cycle(0);

        // Clamp of 0 and 1 to 2.
        req[1] = 1'b1; req_div1 = 8'd0;
        repeat (15) cycle(0);
        req[1] = 1'b1; req_div1 = 8'd1;
        repeat (15) cycle(0);

        // Random traffic with en toggling.
        for (int k = 0; k < 3000; k++) begin
            cycle(10);
            if (en) begin
                if ($urandom_range(99) < 3) en = 1'b0;
            end else begin
                if ($urandom_range(99) < 30) en = 1'b1;
            end
        end

        // Asynchronous reset while an update is pending.
        en = 1'b1;
        repeat (3) cycle(0);
        req = 2'b01; req_div0 = 8'd7;
        for (int k = 0; k < 200 && !(m_busy && m_gnt == 2'b00 && m_run); k++) cycle(0);
        check("pend_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_tick", 32'(div_tick), 32'd0);
        check("arst_out",  32'(div_out),  32'd0);
        check("arst_busy", 32'(busy),     32'd0);
        check("arst_gnt",  32'(gnt),      32'd0);
        check("arst_div",  32'(cur_div),  32'd5);
        model_reset();
        req = 2'b00;
        cycle(0);
        rst = 1'b1;
        repeat (12) cycle(0);

        // Steady ratio 3 for the period counter, then en low.
        req[1] = 1'b1; req_div1 = 8'd3;
        repeat (40) cycle(0);
        en = 1'b0;
        repeat (3) cycle(0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for the programmable clock-enable divider in the clocking path. It generates a divided enable (`div_tick`) and a divided waveform (`div_out`) from `clk_in`. Two requesters share the divide ratio through a round-robin request/grant arbiter. A granted ratio takes effect only at a period boundary, so no output period is ever truncated or stretched.

## Interface
- `CNT_W`, 8: width of the ratio and the period counter.
- `DEF_DIV`, 5: ratio loaded at reset; must be ≥2.
- `clk_in`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; low holds the divider idle.
- `req`  in  2  ratio-change requests, one bit per requester; held until granted.
- `req_div0`  in  CNT_W  ratio offered by requester 0; sampled on its grant cycle.
- `req_div1`  in  CNT_W  ratio offered by requester 1; sampled on its grant cycle.
- `gnt`  out  2  one-hot, one-cycle grant pulse.
- `busy`  out  1  high while a granted ratio is waiting for a boundary.
- `cur_div`  out  CNT_W  ratio currently in effect.
- `div_tick`  out  1  one-cycle pulse in the last cycle of each period.
- `div_out`  out  1  divided waveform: high for the first floor(N/2) cycles of each period.

## Operation
- Reset values: state=IDLE, count=0, `cur_div`=DEF_DIV, pending ratio=0, RR pointer=requester 0.
- Reset values: `gnt`=0, `busy`=0, `div_tick`=0, `div_out`=0.
- States:
  - IDLE: `en`=0; count and outputs held at 0.
  - RUN: counting with no update pending.
  - PEND: counting with a granted ratio waiting.
- IDLE→RUN when `en` is sampled high.
- RUN→PEND on a grant.
- PEND→RUN at the boundary cycle (count==N−1), when the pending ratio loads into `cur_div`.
- Any state→IDLE when `en` is sampled low. A pending ratio is applied on this transition.
- Count runs 0..N−1 and wraps to 0, where N=`cur_div`.
- `div_tick`=1 iff count==N−1.
- `div_out`=1 iff count<floor(N/2). Example N=5: pattern 1,1,0,0,0.
- Arbitration runs only in IDLE or RUN. It does not run in PEND.
  - The pointer-preferred requester wins if requesting; otherwise the other requester wins.
  - After a grant to requester i, the pointer moves to the other requester.
  - `req` is ignored during PEND and stays pending at the requester.
- In IDLE, a grant loads `cur_div` on the next edge; `busy` pulses for one cycle.
- Ratio arithmetic: a requested value of 0 or 1 is clamped to 2. All other values are used as-is, unsigned.
- A grant in the boundary cycle itself is deferred to the next period boundary. It is not merged into the wrapping edge.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- `en` is sampled high at edge E0. The first RUN cycle follows E0 with count=0 and `div_out`=1.
- `div_tick` then asserts at cycle N−1 after E0 and every N cycles after that.
- `gnt` asserts one cycle after `req` is sampled, provided the block is not in PEND. `busy` rises in the same cycle.
- The new ratio applies to the period that starts on the edge after the boundary cycle.
- `busy` falls on that same edge. `cur_div` changes on that same edge.
- Reset asserted mid-period forces all reset values immediately, asynchronously. Release is sampled on the next rising edge.
- `en` low mid-period: outputs are 0 from the next cycle. Re-enable always restarts at count 0.

## Configuration
- `CLK_DIV_CTRL_STATS_EN` defined:
  - adds output `period_cnt` (16 bits), reset 0;
  - increments on every `div_tick`;
  - saturates at 0xFFFF;
  - clears when `en` falls.
- Macro undefined: the `period_cnt` port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `clk_div_pkg`:
  - state enum: IDLE, RUN, PEND;
  - `MIN_DIV`=2;
  - `NUM_REQ`=2.
- One sub-module, `rr_arb2`: 2-way round-robin arbiter. Inputs are `req` and an advance strobe; output is a one-hot grant.
- The FSM, counter and clamp logic live in the top level.

## Test plan
- Reset, then `en`=1 with DEF_DIV=5 → `div_out` repeats 1,1,0,0,0; `div_tick` at cycles 4, 9, 14; `cur_div`=5.
- Mid-period (count=1), `req[0]`=1 with `req_div0`=3 → `gnt`=01 next cycle; `busy`=1 until the boundary at count 4; then the period is 3 (pattern 1,0,0) and `busy`=0.
- `req`=11 at the same time, values 4 and 6, with the pointer reset → requester 0 granted first, giving N=4. Requester 1 is granted after the boundary, and N=6 follows on the next boundary.
- `req_div1`=0, then 1 → `cur_div`=2 in both cases; `div_out` alternates 1,0; `div_tick` every 2 cycles.
- Reset asserted at count 3 with an update pending → outputs 0 immediately, `cur_div`=5, `busy`=0; after release and `en`=1, counting restarts at 0.
- With `CLK_DIV_CTRL_STATS_EN`: 10 periods at N=3 → `period_cnt`=10. After `en` falls, `period_cnt`=0.
